grid_lsq_responder: RTL and testbench

//  LSQ-side responder for one RCA grid slot: accepts slot load/store requests,

---
 rtl/grid_lsq_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_grid_lsq_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_lsq_responder.sv
// LSQ-side responder for one RCA grid slot: request queue, word-aligned memory issue,
// in-order load return. Optional performance counters under `RCA_LSQ_PERF_EN`.
module grid_lsq_responder #(
  parameter int XLEN      = 32,
  parameter int REQ_DEPTH = 4,
  parameter int MAX_LOADS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_we,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            misaligned_err
`ifdef RCA_LSQ_PERF_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_full_cycles
`endif
);

  localparam int QAW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int TAW = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam logic [QAW:0]   Q_FULL = (QAW+1)'(REQ_DEPTH);
  localparam logic [TAW:0]   T_FULL = (TAW+1)'(MAX_LOADS);
  localparam logic [QAW-1:0] Q_LAST = QAW'(REQ_DEPTH - 1);
  localparam logic [TAW-1:0] T_LAST = TAW'(MAX_LOADS - 1);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            we;
    logic [2:0]      fn3;
    logic [1:0]      off;
  } req_t;

  typedef struct packed {
    logic [2:0] fn3;
    logic [1:0] off;
  } trk_t;

  // request decode: lane offset is forced aligned for misaligned half/word
  logic [1:0]      req_off;
  logic [1:0]      req_aoff;
  logic [3:0]      req_be;
  logic [XLEN-1:0] req_wdata;
  logic            req_mis;
  req_t            push_entry;

  always_comb begin
    req_off   = addr[1:0];
    req_aoff  = req_off;
    req_be    = 4'b0000;
    req_wdata = data;
    req_mis   = 1'b0;
    case (fn3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = XLEN'({4{data[7:0]}});
      end
      2'b01: begin
        req_aoff  = {req_off[1], 1'b0};
        req_be    = 4'b0011 << req_aoff;
        req_wdata = XLEN'({2{data[15:0]}});
        req_mis   = req_off[0];
      end
      default: begin
        req_aoff  = 2'b00;
        req_be    = 4'b1111;
        req_wdata = data;
        req_mis   = (req_off != 2'b00);
      end
    endcase
    push_entry.addr  = {addr[XLEN-1:2], 2'b00};
    push_entry.wdata = req_wdata;
    push_entry.be    = req_be;
    push_entry.we    = store;
    push_entry.fn3   = fn3;
    push_entry.off   = req_aoff;
  end

  // request queue
  req_t           q_mem [REQ_DEPTH];
  logic [QAW-1:0] q_wr;
  logic [QAW-1:0] q_rd;
  logic [QAW:0]   q_cnt;
  logic [QAW:0]   q_cnt_nxt;
  logic           push;
  logic           pop;
  req_t           head;

  // outstanding-load tracker
  trk_t           t_mem [MAX_LOADS];
  logic [TAW-1:0] t_wr;
  logic [TAW-1:0] t_rd;
  logic [TAW:0]   t_cnt;
  logic           t_push;
  logic           t_pop;
  logic           t_full;
  trk_t           t_head;

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (p == Q_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TAW-1:0] t_inc(input logic [TAW-1:0] p);
    return (p == T_LAST) ? '0 : p + 1'b1;
  endfunction

  assign push   = new_request && !lsq_full && (load ^ store);
  assign head   = q_mem[q_rd];
  assign t_full = (t_cnt == T_FULL);
  // a load at the head stalls while the tracker is full; everything behind it waits
  assign mem_req_valid = (q_cnt != '0) && !(!head.we && t_full);
  assign pop    = mem_req_valid && mem_req_ready;
  assign t_push = pop && !head.we;
  assign t_pop  = mem_rsp_valid && (t_cnt != '0);
  assign t_head = t_mem[t_rd];

  assign mem_addr  = mem_req_valid ? head.addr  : '0;
  assign mem_wdata = mem_req_valid ? head.wdata : '0;
  assign mem_be    = mem_req_valid ? head.be    : 4'b0000;
  assign mem_we    = mem_req_valid ? head.we    : 1'b0;

  always_comb begin
    case ({push, pop})
      2'b10:   q_cnt_nxt = q_cnt + 1'b1;
      2'b01:   q_cnt_nxt = q_cnt - 1'b1;
      default: q_cnt_nxt = q_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      lsq_full <= 1'b0;
    end else begin
      if (push) q_wr <= q_inc(q_wr);
      if (pop)  q_rd <= q_inc(q_rd);
      q_cnt    <= q_cnt_nxt;
      lsq_full <= (q_cnt_nxt == Q_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (t_push) t_mem[t_wr] <= '{fn3: head.fn3, off: head.off};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_wr  <= '0;
      t_rd  <= '0;
      t_cnt <= '0;
    end else begin
      if (t_push) t_wr <= t_inc(t_wr);
      if (t_pop)  t_rd <= t_inc(t_rd);
      case ({t_push, t_pop})
        2'b10:   t_cnt <= t_cnt + 1'b1;
        2'b01:   t_cnt <= t_cnt - 1'b1;
        default: t_cnt <= t_cnt;
      endcase
    end
  end

  // response lane select and extension
  logic [XLEN-1:0] rsp_lane;
  logic [XLEN-1:0] rsp_ext;

  always_comb begin
    rsp_lane = mem_rdata >> {t_head.off, 3'b000};
    case (t_head.fn3[1:0])
      2'b00:   rsp_ext = t_head.fn3[2] ? {{(XLEN-8){1'b0}}, rsp_lane[7:0]}
                                       : {{(XLEN-8){rsp_lane[7]}}, rsp_lane[7:0]};
      2'b01:   rsp_ext = t_head.fn3[2] ? {{(XLEN-16){1'b0}}, rsp_lane[15:0]}
                                       : {{(XLEN-16){rsp_lane[15]}}, rsp_lane[15:0]};
      default: rsp_ext = rsp_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_complete  <= 1'b0;
      load_data      <= '0;
      misaligned_err <= 1'b0;
    end else begin
      load_complete <= t_pop;
      if (t_pop) load_data <= rsp_ext;
      if (push && req_mis) misaligned_err <= 1'b1;
    end
  end

`ifdef RCA_LSQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads       <= '0;
      perf_stores      <= '0;
      perf_full_cycles <= '0;
    end else begin
      if (t_push && (perf_loads != '1))              perf_loads       <= perf_loads + 1'b1;
      if (pop && head.we && (perf_stores != '1))     perf_stores      <= perf_stores + 1'b1;
      if (lsq_full && (perf_full_cycles != '1))      perf_full_cycles <= perf_full_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_grid_lsq_responder.sv
// Self-checking bench for grid_lsq_responder: directed cases then random traffic
// against a queue-based reference model.
module tb_grid_lsq_responder;

  localparam int QDEPTH = 4;
  localparam int MAXL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic [2:0]  fn3 = '0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic        new_request = 1'b0;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        misaligned_err;

  grid_lsq_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load), .store(store),
    .new_request(new_request), .lsq_full(lsq_full), .load_data(load_data),
    .load_complete(load_complete), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic [2:0]  f;
    logic [1:0]  off;
    logic        mis;
  } mreq_t;

  mreq_t       pend[$];
  mreq_t       trk[$];
  logic [31:0] issued_log[$];
  logic        exp_pulse = 1'b0;
  logic [31:0] exp_ld = '0;
  logic        mis_m = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic mreq_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, input logic st);
    mreq_t r;
    int sz, off, aoff;
    sz   = size_of(f);
    off  = int'(a[1:0]);
    aoff = (off / sz) * sz;
    r.a   = a - 32'(off);
    r.be  = 4'(((1 << sz) - 1) << aoff);
    r.wd  = (sz == 1) ? {24'b0, d[7:0]} * 32'h0101_0101 :
            (sz == 2) ? {16'b0, d[15:0]} * 32'h0001_0001 : d;
    r.we  = st;
    r.f   = f;
    r.off = 2'(aoff);
    r.mis = (aoff != off);
    return r;
  endfunction

  function automatic logic [31:0] ext(input mreq_t t, input logic [31:0] rd);
    int sz;
    logic [31:0] mask, v;
    sz   = size_of(t.f);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v    = (rd >> (8 * int'(t.off))) & mask;
    if (!t.f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // check current outputs against the model, drive one cycle, advance the model
  task automatic step(input logic nr, input logic ld, input logic st,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input logic rdy, input logic rv, input logic [31:0] rd);
    mreq_t r, h, t;
    logic  exp_valid, full_b;
    full_b    = (pend.size() == QDEPTH);
    exp_valid = (pend.size() > 0) && !(!pend[0].we && trk.size() == MAXL);
    chk("lsq_full", lsq_full, full_b);
    chk("mem_req_valid", mem_req_valid, exp_valid);
    if (exp_valid) begin
      chk("mem_addr", mem_addr, pend[0].a);
      chk("mem_be", mem_be, pend[0].be);
      chk("mem_wdata", mem_wdata, pend[0].wd);
      chk("mem_we", mem_we, pend[0].we);
    end
    chk("load_complete", load_complete, exp_pulse);
    chk("load_data", load_data, exp_ld);
    chk("misaligned_err", misaligned_err, mis_m);
    if (mem_req_valid && rdy) issued_log.push_back(mem_addr);

    new_request = nr; load = ld; store = st; addr = a; data = d; fn3 = f;
    mem_req_ready = rdy; mem_rsp_valid = rv; mem_rdata = rd;

    exp_pulse = rv && (trk.size() > 0);
    if (exp_pulse) begin
      t = trk.pop_front();
      exp_ld = ext(t, rd);
    end
    if (exp_valid && rdy) begin
      h = pend.pop_front();
      if (!h.we) trk.push_back(h);
    end
    if (nr && !full_b && (ld ^ st)) begin
      r = mk(a, d, f, st);
      pend.push_back(r);
      if (r.mis) mis_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, rdy, 1'b0, 32'h0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_lsq_full"}, lsq_full, 0);
    chk({p, "_load_complete"}, load_complete, 0);
    chk({p, "_load_data"}, load_data, 0);
    chk({p, "_mem_req_valid"}, mem_req_valid, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_be"}, mem_be, 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_misaligned_err"}, misaligned_err, 0);
  endtask

  initial begin
    logic [2:0] lf [5];
    logic [2:0] f;
    logic       nr, ld, st, rdy, rv;
    int         kind;
    lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: LBU 0x103
    step(1, 1, 0, 32'h103, 32'h0, 3'b100, 0, 0, 0);
    chk("t1_mem_be", mem_be, 4'b1000);
    chk("t1_mem_addr", mem_addr, 32'h100);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hAB00_0000);
    chk("t1_pulse", load_complete, 1);
    chk("t1_load_data", load_data, 32'h0000_00AB);
    idle(0);

    // 2: LH 0x202 sign-extended
    step(1, 1, 0, 32'h202, 32'h0, 3'b001, 0, 0, 0);
    chk("t2_mem_be", mem_be, 4'b1100);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_0000);
    chk("t2_pulse", load_complete, 1);
    chk("t2_load_data", load_data, 32'hFFFF_8001);
    idle(0);
    chk("t2_pulse_end", load_complete, 0);

    // 3: SB 0x301
    step(1, 0, 1, 32'h301, 32'h0000_005A, 3'b000, 0, 0, 0);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_be", mem_be, 4'b0010);
    chk("t3_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
    idle(1);
    chk("t3_no_pulse", load_complete, 0);
    idle(0);

    // 4: five stores with memory stalled, then release
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, 32'h500 + 32'(4 * i), 32'(i), 3'b010, 0, 0, 0);
    chk("t4_full", lsq_full, 1);
    issued_log.delete();
    repeat (6) idle(1);
    chk("t4_issued", 32'(issued_log.size()), 4);
    for (int i = 0; i < issued_log.size(); i++)
      chk("t4_order", issued_log[i], 32'h500 + 32'(4 * i));

    // 5: misaligned LW
    step(1, 1, 0, 32'h402, 32'h0, 3'b010, 0, 0, 0);
    chk("t5_mem_addr", mem_addr, 32'h400);
    chk("t5_mem_be", mem_be, 4'hF);
    chk("t5_mis", misaligned_err, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    repeat (3) idle(0);
    chk("t5_mis_held", misaligned_err, 1);

    // 6: reset with two loads outstanding
    step(1, 1, 0, 32'h600, 32'h0, 3'b010, 0, 0, 0);
    step(1, 1, 0, 32'h604, 32'h0, 3'b010, 1, 0, 0);
    idle(1);
    idle(0);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("t6");
    pend.delete(); trk.delete();
    exp_pulse = 1'b0; exp_ld = '0; mis_m = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t6_no_pulse", load_complete, 0);
    idle(0);

    // random traffic; first half keeps responses rare to exercise tracker stalls
    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      ld = (kind == 0) || (kind >= 2 && kind <= 5);
      st = (kind == 0) || (kind >= 6);
      f  = ld && !st ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      nr  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (i < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      step(nr, ld, st, $urandom & 32'h0000_FFFF, $urandom, f, rdy, rv, $urandom);
    end
    repeat (30) step(0, 0, 0, 0, 0, 0, 1, 1, $urandom);
    chk("drain_pend", 32'(pend.size()), 0);
    chk("drain_trk", 32'(trk.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
